// File: rtl/unsigned_restoring_divider58_37_pkg.sv
// Shared widths, state encoding and counter sizing for the
// 58/37 restoring divider.
package unsigned_restoring_divider58_37_pkg;

  localparam int DIVIDEND_W = 58;
  localparam int DIVISOR_W  = 37;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/unsigned_restoring_divider58_37_trial_subtractor38.sv
// Ripple-borrow subtractor used for the per-cycle trial compare.
// no_borrow is high when a >= b.
module trial_subtractor38
  import unsigned_restoring_divider58_37_pkg::*;
#(
  parameter int W = DIVISOR_W + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] brw;

  always_comb begin
    brw     = '0;
    diff    = '0;
    for (int i = 0; i < W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
    no_borrow = ~brw[W];
  end

endmodule

// File: rtl/unsigned_restoring_divider58_37.sv
// Multi-cycle unsigned restoring divider, one quotient bit per
// cycle, valid/ready on both the operand and result sides.
module unsigned_restoring_divider58_37
  import unsigned_restoring_divider58_37_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;
  logic                  no_borrow;
  logic                  r_top_unused;

  assign trial = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};

  trial_subtractor38 #(.W(DIVISOR_W + 1)) u_sub (
    .a         (trial),
    .b         ({1'b0, d_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid) begin
          d_d   = divisor;
          cnt_d = CNT_W'(DIVIDEND_W - 1);
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, dividend[DIVISOR_W-1:0]};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = S_BUSY;
          end
        end
      end
      state_q == S_BUSY: begin
        // Restore by simply keeping the shifted value when the trial borrows
        r_d   = no_borrow ? diff : trial;
        q_d   = {q_q[DIVIDEND_W-2:0], no_borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      state_q == S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
    end
  end

  assign r_top_unused = r_q[DIVISOR_W];
  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign quotient     = q_q;
  assign remainder    = r_q[DIVISOR_W-1:0];
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_unsigned_restoring_divider58_37.sv
// Self-checking bench: directed vector table, random operands against
// an arithmetic model, and handshake/reset corner sequences.
module tb_unsigned_restoring_divider58_37;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [57:0] dividend;
  logic [36:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [57:0] quotient;
  logic [36:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unsigned_restoring_divider58_37 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [57:0] a;
    logic [36:0] b;
    logic [57:0] eq;
    logic [36:0] er;
    logic        edbz;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: plain integer division on 64-bit values
  task automatic model(input logic [57:0] a, input logic [36:0] b,
                       output logic [57:0] q, output logic [36:0] r,
                       output logic dbz);
    logic [63:0] a64, b64, q64, r64;
    if (b == 0) begin
      q   = '1;
      r   = a[36:0];
      dbz = 1'b1;
    end else begin
      a64 = {6'd0, a};
      b64 = {27'd0, b};
      q64 = a64 / b64;
      r64 = a64 % b64;
      q   = q64[57:0];
      r   = r64[36:0];
      dbz = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic [57:0] a, input logic [36:0] b);
    wait_ready();
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_chk(input string tag, input logic [57:0] a,
                         input logic [36:0] b, input logic [57:0] eq,
                         input logic [36:0] er, input logic edbz,
                         input bit chk_lat);
    int lat;
    issue(a, b);
    wait_done(lat);
    if (chk_lat) chk({tag, "_lat"}, 64'(lat), (b == 0) ? 64'd0 : 64'd58);
    chk({tag, "_q"}, 64'(quotient), 64'(eq));
    chk({tag, "_r"}, 64'(remainder), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    consume();
  endtask

  initial begin
    logic [57:0] mq, sq;
    logic [36:0] mr, sr;
    logic        mdbz;
    logic [63:0] t64;
    logic [57:0] ra;
    logic [36:0] rb;
    int          lat;

    tbl[0] = '{58'd100, 37'd7, 58'd14, 37'd2, 1'b0};
    tbl[1] = '{{58{1'b1}}, 37'd1, {58{1'b1}}, 37'd0, 1'b0};
    tbl[2] = '{{58{1'b1}}, {37{1'b1}}, 58'd2097152, 37'd2097151, 1'b0};
    tbl[3] = '{58'd5, 37'd9, 58'd0, 37'd5, 1'b0};
    tbl[4] = '{58'd1234, 37'd0, {58{1'b1}}, 37'd1234, 1'b1};
    tbl[5] = '{58'd63, 37'd63, 58'd1, 37'd0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].eq, tbl[i].er, tbl[i].edbz, 1'b1);

    for (int i = 0; i < 40; i++) begin
      t64 = {$urandom(), $urandom()};
      ra  = t64[57:0] >> $urandom_range(0, 57);
      t64 = {$urandom(), $urandom()};
      rb  = t64[36:0] >> $urandom_range(0, 36);
      if ($urandom_range(0, 9) == 0) rb = '0;
      model(ra, rb, mq, mr, mdbz);
      run_chk($sformatf("rnd%0d", i), ra, rb, mq, mr, mdbz, 1'b0);
    end

    // Backpressure: result must hold and new operands must be ignored
    issue(58'd100, 37'd7);
    wait_done(lat);
    sq = quotient;
    sr = remainder;
    chk("bp_q", 64'(sq), 64'd14);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      dividend = 58'(i + 900);
      divisor  = 37'(i + 3);
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_q", 64'(quotient), 64'(sq));
      chk("bp_hold_r", 64'(remainder), 64'(sr));
    end
    in_valid  = 1'b1;
    dividend  = 58'd5;
    divisor   = 37'd9;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_ready_after_consume", 64'(in_ready), 64'd1);
    chk("b2b_valid_after_consume", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'd58);
    chk("b2b_q", 64'(quotient), 64'd0);
    chk("b2b_r", 64'(remainder), 64'd5);
    consume();

    // Reset during BUSY aborts without producing a result
    issue(58'd987654321, 37'd12345);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("mid_rst_still_idle", 64'(out_valid), 64'd0);
    run_chk("post_rst", 58'd100, 37'd7, 58'd14, 37'd2, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
